mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Multi-channel successor to the single-port RAM wrapper: NUM_CH requesters (systolic-array loaders, result drainers, host) share one single-port IP RAM.
- Round-robin arbitration with a per-channel valid/ready request interface and byte/half/word access.
- Latency-matched, channel-tagged responses, one per accepted request.
- Error reporting and throughput counters. The IP RAM is instantiated outside; this block drives its pins.

Parameters:
- NUM_CH, 4, number of requesting channels (1..8)
- ADDR_WIDTH, 32, byte-address width of request ports
- DEPTH_WORDS, 8192, RAM depth in 32-bit words (power of two); RAW = clog2(DEPTH_WORDS)
- READ_LATENCY, 2, RAM read latency in cycles (1..4)
- INIT_CYCLES, 16, post-reset cycles before requests are accepted

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel request accepted this cycle
- req_we  in  NUM_CH  1=write, 0=read
- req_size  in  2*NUM_CH  per channel: 00 byte, 01 half, 10 word, 11 illegal
- req_addr  in  ADDR_WIDTH*NUM_CH  byte addresses
- req_wdata  in  32*NUM_CH  write data, LSB-aligned
- rsp_valid  out  NUM_CH  one-hot response pulse
- rsp_we  out  1  response belongs to a write
- rsp_err  out  1  request was rejected
- rsp_rdata  out  32  zero-extended read data
- ram_addr  out  RAW  word address to IP RAM
- ram_byteena  out  4  byte lane enables
- ram_wdata  out  32  lane-replicated write data
- ram_wren  out  1  RAM write enable
- ram_rden  out  1  RAM read enable
- ram_q  in  32  RAM read data
- init_done  out  1  init phase complete
- read_count  out  32  completed error-free reads
- write_count  out  32  completed error-free writes
- bytes_transferred  out  32  bytes moved by error-free accesses
- error_count  out  32  rejected requests
- conflict_cycles  out  32  cycles with more than one req_valid while init_done

Behaviour:
- Reset values: every output is 0, the RR pointer is 0, the pipeline is empty, and init_cnt is 0.
- Init phase:
  - init_done rises after INIT_CYCLES clock edges following reset deassertion.
  - While init_done=0, all req_ready=0 and all RAM enables are 0.
- Arbitration:
  - Combinational. Grant goes to the first valid channel at or after the RR pointer, scanning upward modulo NUM_CH.
  - req_ready[g]=1 only for the granted channel, and only when init_done=1. req_ready may depend on req_valid.
  - The pointer advances to g+1 (mod NUM_CH) on each accept and holds when nothing is accepted.
  - At most one request is accepted per cycle.
  - A requester must hold valid and payload stable until ready.
- Legality: a request is an error if any of the following holds:
  - size=11
  - addr ≥ 4*DEPTH_WORDS
  - half with addr[0]≠0
  - word with addr[1:0]≠0
- Erroneous requests are accepted, do not touch the RAM, and still produce a response.
- RAM drive, in the accept cycle and for legal requests only:
  - ram_addr = addr[RAW+1:2].
  - byteena: byte → one-hot on addr[1:0]; half → 0011 or 1100 on addr[1]; word → 1111.
  - wdata: byte replicated ×4; half replicated ×2; word passed through.
  - ram_rden = !we; ram_wren = we.
- Response pipeline:
  - Each accepted request pushes the tag {ch, we, size, addr[1:0], err} into a READ_LATENCY-deep shift register.
  - A response appears exactly READ_LATENCY cycles after the accepting edge: rsp_valid has a 1-cycle pulse on channel ch.
  - Read data extracts the addressed byte or half from ram_q and zero-extends it.
  - rsp_rdata = 0 for writes, for errors, and when rsp_valid = 0.
  - Responses have no backpressure; throughput is one request per cycle.
- RAW hazard: no forwarding. A read accepted any cycle after a write to the same word returns the new data.
- Counters:
  - Counters update on response, are modulo 2^32, and all held at 0 during reset.
  - bytes_transferred adds 1, 2 or 4.
  - A read and a write cannot complete in the same cycle, so no double-add is possible.
- Reset mid-operation: in-flight tags are discarded with no responses emitted, counters clear, and init restarts.

Decomposition:
- Package mem_arb_pkg holds:
  - the size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
  - the rsp_tag_t struct
  - the lane_enable() and extract_lane() functions
- One sub-module, rr_arbiter (NUM_CH param): req vector in, one-hot grant out, advance input, pointer state.

Test Plan:
- Single read: ch0 reads word 0x10 after init with RAM preloaded 0xDEADBEEF → req_ready at cycle of valid; rsp_valid=0001 two cycles later; rsp_rdata=0xDEADBEEF; read_count=1, bytes=4.
- Byte/half write and readback: ch1 writes byte 0xAB to 0x21, then half 0x1234 to 0x22, then word read 0x20 → byteena 0010 then 1100; readback 0x1234AB00 (word previously 0); bytes_transferred=1+2+4=7.
- Round-robin fairness: all 4 channels hold valid with pointer=0 → grants 0,1,2,3,0 on consecutive cycles; conflict_cycles increments every cycle; responses return in grant order.
- Errors:
  - word read at 0x22 → rsp_err=1, data 0, RAM enables 0, error_count=1, read_count unchanged.
  - addr 0x8000 → error.
  - size=11 → error.
- Init gating: req_valid asserted from reset release → req_ready=0 for 16 cycles; first accept on the cycle init_done=1.
- Reset mid-flight: assert reset one cycle after a read accept → no rsp_valid pulse; all counters 0; init_done=0 for 16 cycles after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and lane helpers for the multi-channel RAM port arbiter.
// Lane functions map a byte address offset and access size onto the 32-bit RAM word.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Channel field is sized for the largest supported NUM_CH (8).
  localparam int CH_W = 3;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
    logic            we;
    size_e           size;
    logic [1:0]      off;
    logic            err;
  } rsp_tag_t;

  function automatic logic [3:0] lane_enable(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: lane_enable = 4'b0001 << off;
      SZ_HALF: lane_enable = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_enable = 4'b1111;
      default: lane_enable = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extract_lane(logic [31:0] q, size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: extract_lane = {24'h0, q[{off, 3'b000} +: 8]};
      SZ_HALF: extract_lane = off[1] ? {16'h0, q[31:16]} : {16'h0, q[15:0]};
      default: extract_lane = q;
    endcase
  endfunction

  function automatic logic [31:0] replicate_lanes(size_e size, logic [31:0] wdata);
    case (size)
      SZ_BYTE: replicate_lanes = {4{wdata[7:0]}};
      SZ_HALF: replicate_lanes = {2{wdata[15:0]}};
      default: replicate_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] size_bytes(size_e size);
    case (size)
      SZ_BYTE: size_bytes = 32'd1;
      SZ_HALF: size_bytes = 32'd2;
      default: size_bytes = 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// pointer moves past the granted channel whenever the grant is consumed.
module rr_arbiter #(
  parameter int  NUM_CH = 4,
  localparam int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [PW-1:0]     grant_idx_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
      idx = (idx == PW'(NUM_CH - 1)) ? '0 : idx + PW'(1);
    end
    ptr_d = (grant_idx_o == PW'(NUM_CH - 1)) ? '0 : grant_idx_o + PW'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset)          ptr_q <= '0;
    else if (advance_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// NUM_CH requesters share one single-port RAM: round-robin accept, legality check,
// lane-aligned RAM drive, and channel-tagged responses READ_LATENCY cycles later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_CH       = 4,
  parameter int  ADDR_WIDTH   = 32,
  parameter int  DEPTH_WORDS  = 8192,
  parameter int  READ_LATENCY = 2,
  parameter int  INIT_CYCLES  = 16,
  localparam int RAW          = $clog2(DEPTH_WORDS),
  localparam int PW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ICW          = $clog2(INIT_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            req_we,
  input  logic [2*NUM_CH-1:0]          req_size,
  input  logic [ADDR_WIDTH*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]         req_wdata,
  output logic [NUM_CH-1:0]            rsp_valid,
  output logic                         rsp_we,
  output logic                         rsp_err,
  output logic [31:0]                  rsp_rdata,
  output logic [RAW-1:0]               ram_addr,
  output logic [3:0]                   ram_byteena,
  output logic [31:0]                  ram_wdata,
  output logic                         ram_wren,
  output logic                         ram_rden,
  input  logic [31:0]                  ram_q,
  output logic                         init_done,
  output logic [31:0]                  read_count,
  output logic [31:0]                  write_count,
  output logic [31:0]                  bytes_transferred,
  output logic [31:0]                  error_count,
  output logic [31:0]                  conflict_cycles
);

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_CH];
  logic [31:0]           wdata_a [NUM_CH];
  size_e                 size_a  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign addr_a[c]  = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[c] = req_wdata[c*32 +: 32];
    assign size_a[c]  = size_e'(req_size[c*2 +: 2]);
  end

  logic [NUM_CH-1:0] grant;
  logic [PW-1:0]     gidx;
  logic              accept, ram_go, multi_valid;
  logic              init_done_q;
  logic [ICW-1:0]    init_cnt_q;

  logic [ADDR_WIDTH-1:0] sel_addr;
  size_e                 sel_size;
  logic                  sel_we, sel_err;

  rsp_tag_t tag_q [READ_LATENCY];
  rsp_tag_t push_tag, tail;

  logic [31:0] rd_cnt_q, wr_cnt_q, bytes_q, err_cnt_q, conflict_q;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_valid),
    .advance_i   (accept),
    .grant_o     (grant),
    .grant_idx_o (gidx)
  );

  assign accept      = init_done_q && (req_valid != '0);
  assign req_ready   = init_done_q ? grant : '0;
  assign multi_valid = (req_valid & (req_valid - NUM_CH'(1))) != '0;
  assign tail        = tag_q[READ_LATENCY-1];

  always_comb begin
    sel_addr = addr_a[gidx];
    sel_size = size_a[gidx];
    sel_we   = req_we[gidx];
    // Out-of-range check is a shift so it stays correct for any ADDR_WIDTH.
    sel_err  = (sel_size == SZ_ILL)
            || ((sel_addr >> (RAW + 2)) != '0)
            || (sel_size == SZ_HALF && sel_addr[0])
            || (sel_size == SZ_WORD && sel_addr[1:0] != 2'b00);
    ram_go      = accept && !sel_err;
    ram_addr    = ram_go ? sel_addr[RAW+1:2] : '0;
    ram_byteena = ram_go ? lane_enable(sel_size, sel_addr[1:0]) : '0;
    ram_wdata   = ram_go ? replicate_lanes(sel_size, wdata_a[gidx]) : '0;
    ram_wren    = ram_go && sel_we;
    ram_rden    = ram_go && !sel_we;

    push_tag = '0;
    if (accept) begin
      push_tag.vld  = 1'b1;
      push_tag.ch   = CH_W'(gidx);
      push_tag.we   = sel_we;
      push_tag.size = sel_size;
      push_tag.off  = sel_addr[1:0];
      push_tag.err  = sel_err;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int c = 0; c < NUM_CH; c++) rsp_valid[c] = tail.vld && (tail.ch == CH_W'(c));
    rsp_we    = tail.vld && tail.we;
    rsp_err   = tail.vld && tail.err;
    rsp_rdata = (tail.vld && !tail.we && !tail.err) ? extract_lane(ram_q, tail.size, tail.off) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      // NOTE: the tag shift register is reset because its valid bits must never leak stale responses.
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      bytes_q     <= '0;
      err_cnt_q   <= '0;
      conflict_q  <= '0;
    end else begin
      if (!init_done_q) begin
        init_cnt_q <= init_cnt_q + ICW'(1);
        if (init_cnt_q == ICW'(INIT_CYCLES - 1)) init_done_q <= 1'b1;
      end
      tag_q[0] <= push_tag;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (init_done_q && multi_valid) conflict_q <= conflict_q + 32'd1;
      if (tail.vld) begin
        if (tail.err) begin
          err_cnt_q <= err_cnt_q + 32'd1;
        end else begin
          if (tail.we) wr_cnt_q <= wr_cnt_q + 32'd1;
          else         rd_cnt_q <= rd_cnt_q + 32'd1;
          bytes_q <= bytes_q + size_bytes(tail.size);
        end
      end
    end
  end

  assign init_done         = init_done_q;
  assign read_count        = rd_cnt_q;
  assign write_count       = wr_cnt_q;
  assign bytes_transferred = bytes_q;
  assign error_count       = err_cnt_q;
  assign conflict_cycles   = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-2 byte-enabled RAM model.
// Each task drives one scenario and compares against hand-computed values.
module tb_mem_port_arbiter;

  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SI = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [7:0]   req_size;
  logic [127:0] req_addr, req_wdata;
  logic         rsp_we, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [12:0]  ram_addr;
  logic [3:0]   ram_byteena;
  logic [31:0]  ram_wdata, ram_q;
  logic         ram_wren, ram_rden, init_done;
  logic [31:0]  read_count, write_count, bytes_transferred, error_count, conflict_cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_byteena(ram_byteena), .ram_wdata(ram_wdata),
    .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q),
    .init_done(init_done), .read_count(read_count), .write_count(write_count),
    .bytes_transferred(bytes_transferred), .error_count(error_count),
    .conflict_cycles(conflict_cycles)
  );

  // RAM model: address registered on the accept edge, output registered one edge later.
  logic [31:0] mem [0:8191];
  logic [31:0] rd_s1, merged;
  logic        ld_en;
  logic [12:0] ld_addr;
  logic [31:0] ld_data;

  always_comb begin
    merged = mem[ram_addr];
    for (int b = 0; b < 4; b++) if (ram_byteena[b]) merged[8*b +: 8] = ram_wdata[8*b +: 8];
  end

  always @(posedge clk) begin
    if (ld_en)         mem[ld_addr]  <= ld_data;
    else if (ram_wren) mem[ram_addr] <= merged;
    if (ram_rden) rd_s1 <= mem[ram_addr];
    ram_q <= rd_s1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic drive(input int ch, input logic we, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid[ch] = 1'b1;
    req_we[ch] = we;
    req_size[2*ch +: 2] = sz;
    req_addr[32*ch +: 32] = addr;
    req_wdata[32*ch +: 32] = wd;
  endtask

  task automatic test_reset();
    drive(0, 1'b0, SW, 32'h10, 32'h0);
    step();
    if (req_ready !== 4'b0000) begin $display("FAIL reset_ready: got %b want 0000", req_ready); fails++; end
    tests++;
    if ({rsp_valid, rsp_we, rsp_err, rsp_rdata} !== 38'h0) begin
      $display("FAIL reset_rsp: got valid=%b we=%b err=%b rdata=%h want all 0", rsp_valid, rsp_we, rsp_err, rsp_rdata); fails++;
    end
    tests++;
    if ({ram_wren, ram_rden, ram_byteena, ram_addr, ram_wdata} !== 51'h0) begin
      $display("FAIL reset_ram: got wren=%b rden=%b be=%b addr=%h wdata=%h want all 0", ram_wren, ram_rden, ram_byteena, ram_addr, ram_wdata); fails++;
    end
    tests++;
    if ({init_done, read_count, write_count, bytes_transferred, error_count, conflict_cycles} !== 161'h0) begin
      $display("FAIL reset_counters: got init=%b rd=%0d wr=%0d bytes=%0d err=%0d conf=%0d want all 0",
               init_done, read_count, write_count, bytes_transferred, error_count, conflict_cycles); fails++;
    end
    tests++;
  endtask

  task automatic test_init_gating();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if ({init_done, req_ready, ram_rden} !== 6'b0) begin
        $display("FAIL init_gate_c%0d: got init=%b ready=%b rden=%b want 0", i, init_done, req_ready, ram_rden); fails++;
      end
      tests++;
      step();
    end
  endtask

  task automatic test_single_read();
    #1;
    if ({init_done, req_ready} !== 5'b1_0001) begin
      $display("FAIL first_accept: got init=%b ready=%b want 1/0001", init_done, req_ready); fails++;
    end
    tests++;
    if ({ram_rden, ram_wren, ram_byteena, ram_addr} !== {2'b10, 4'hF, 13'd4}) begin
      $display("FAIL read_ram_drive: got rden=%b wren=%b be=%b addr=%h want 1/0/1111/004", ram_rden, ram_wren, ram_byteena, ram_addr); fails++;
    end
    tests++;
    step(); idle(); #1;
    if (rsp_valid !== 4'b0000) begin $display("FAIL read_early_rsp: got %b want 0000", rsp_valid); fails++; end
    tests++;
    step(); #1;
    if ({rsp_valid, rsp_we, rsp_err, rsp_rdata} !== {4'b0001, 2'b00, 32'hDEADBEEF}) begin
      $display("FAIL read_rsp: got valid=%b we=%b err=%b rdata=%h want 0001/0/0/deadbeef", rsp_valid, rsp_we, rsp_err, rsp_rdata); fails++;
    end
    tests++;
    step(); #1;
    if ({rsp_valid, read_count, bytes_transferred} !== {4'b0, 32'd1, 32'd4}) begin
      $display("FAIL read_counts: got valid=%b rd=%0d bytes=%0d want 0000/1/4", rsp_valid, read_count, bytes_transferred); fails++;
    end
    tests++;
  endtask

  task automatic test_byte_half();
    drive(1, 1'b1, SB, 32'h21, 32'hAB); #1;
    if ({req_ready, ram_wren, ram_rden, ram_addr, ram_byteena, ram_wdata} !== {4'b0010, 2'b10, 13'd8, 4'b0010, 32'hABABABAB}) begin
      $display("FAIL byte_write_drive: got ready=%b wren=%b rden=%b addr=%h be=%b wdata=%h want 0010/1/0/008/0010/abababab",
               req_ready, ram_wren, ram_rden, ram_addr, ram_byteena, ram_wdata); fails++;
    end
    tests++;
    step(); drive(1, 1'b1, SH, 32'h22, 32'h1234); #1;
    if ({req_ready, ram_wren, ram_byteena, ram_wdata} !== {4'b0010, 1'b1, 4'b1100, 32'h12341234}) begin
      $display("FAIL half_write_drive: got ready=%b wren=%b be=%b wdata=%h want 0010/1/1100/12341234", req_ready, ram_wren, ram_byteena, ram_wdata); fails++;
    end
    tests++;
    step(); drive(1, 1'b0, SW, 32'h20, 32'h0); #1;
    if ({req_ready, ram_rden, rsp_valid, rsp_we, rsp_rdata} !== {4'b0010, 1'b1, 4'b0010, 1'b1, 32'h0}) begin
      $display("FAIL byte_write_rsp: got ready=%b rden=%b valid=%b we=%b rdata=%h want 0010/1/0010/1/0", req_ready, ram_rden, rsp_valid, rsp_we, rsp_rdata); fails++;
    end
    tests++;
    step(); idle(); #1;
    if ({rsp_valid, rsp_we} !== {4'b0010, 1'b1}) begin
      $display("FAIL half_write_rsp: got valid=%b we=%b want 0010/1", rsp_valid, rsp_we); fails++;
    end
    tests++;
    step(); #1;
    if ({rsp_valid, rsp_we, rsp_rdata} !== {4'b0010, 1'b0, 32'h1234AB00}) begin
      $display("FAIL readback_rsp: got valid=%b we=%b rdata=%h want 0010/0/1234ab00", rsp_valid, rsp_we, rsp_rdata); fails++;
    end
    tests++;
    step(); #1;
    // Running totals: 4 bytes from the first read plus 1+2+4 here.
    if ({read_count, write_count, bytes_transferred} !== {32'd2, 32'd2, 32'd11}) begin
      $display("FAIL byte_half_counts: got rd=%0d wr=%0d bytes=%0d want 2/2/11", read_count, write_count, bytes_transferred); fails++;
    end
    tests++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    // A lone ch3 accept moves the pointer from 2 to 0.
    drive(3, 1'b0, SW, 32'h10, 32'h0); #1;
    if (req_ready !== 4'b1000) begin $display("FAIL rr_prime_ready: got %b want 1000", req_ready); fails++; end
    tests++;
    step(); idle(); step(); #1;
    if ({rsp_valid, rsp_rdata} !== {4'b1000, 32'hDEADBEEF}) begin
      $display("FAIL rr_prime_rsp: got valid=%b rdata=%h want 1000/deadbeef", rsp_valid, rsp_rdata); fails++;
    end
    tests++;
    for (int c = 0; c < 4; c++) drive(c, 1'b0, SW, 32'h10, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (req_ready !== exp[i]) begin $display("FAIL rr_grant_%0d: got %b want %b", i, req_ready, exp[i]); fails++; end
      tests++;
      if (i >= 2) begin
        if (rsp_valid !== exp[i-2]) begin $display("FAIL rr_rsp_%0d: got %b want %b", i - 2, rsp_valid, exp[i-2]); fails++; end
        tests++;
      end
      step();
    end
    idle(); #1;
    if ({conflict_cycles, rsp_valid} !== {32'd5, exp[3]}) begin
      $display("FAIL rr_conflict: got conf=%0d valid=%b want 5/1000", conflict_cycles, rsp_valid); fails++;
    end
    tests++;
    step(); #1;
    if ({rsp_valid, rsp_rdata} !== {exp[4], 32'hDEADBEEF}) begin
      $display("FAIL rr_rsp_4: got valid=%b rdata=%h want 0001/deadbeef", rsp_valid, rsp_rdata); fails++;
    end
    tests++;
    step(); #1;
    if ({rsp_valid, read_count, bytes_transferred, conflict_cycles} !== {4'b0, 32'd8, 32'd35, 32'd5}) begin
      $display("FAIL rr_counts: got valid=%b rd=%0d bytes=%0d conf=%0d want 0000/8/35/5", rsp_valid, read_count, bytes_transferred, conflict_cycles); fails++;
    end
    tests++;
  endtask

  task automatic test_errors();
    drive(1, 1'b0, SW, 32'h22, 32'h0); #1;
    if ({req_ready, ram_wren, ram_rden, ram_byteena} !== {4'b0010, 6'b0}) begin
      $display("FAIL err_misalign_drive: got ready=%b wren=%b rden=%b be=%b want 0010/0/0/0000", req_ready, ram_wren, ram_rden, ram_byteena); fails++;
    end
    tests++;
    step(); idle(); drive(2, 1'b0, SW, 32'h8000, 32'h0); #1;
    if ({req_ready, ram_wren, ram_rden, ram_byteena} !== {4'b0100, 6'b0}) begin
      $display("FAIL err_range_drive: got ready=%b wren=%b rden=%b be=%b want 0100/0/0/0000", req_ready, ram_wren, ram_rden, ram_byteena); fails++;
    end
    tests++;
    step(); idle(); drive(3, 1'b1, SI, 32'h0, 32'h55); #1;
    if ({req_ready, ram_wren, ram_rden, ram_byteena} !== {4'b1000, 6'b0}) begin
      $display("FAIL err_size_drive: got ready=%b wren=%b rden=%b be=%b want 1000/0/0/0000", req_ready, ram_wren, ram_rden, ram_byteena); fails++;
    end
    tests++;
    if ({rsp_valid, rsp_we, rsp_err, rsp_rdata} !== {4'b0010, 2'b01, 32'h0}) begin
      $display("FAIL err_misalign_rsp: got valid=%b we=%b err=%b rdata=%h want 0010/0/1/0", rsp_valid, rsp_we, rsp_err, rsp_rdata); fails++;
    end
    tests++;
    step(); idle(); #1;
    if ({rsp_valid, rsp_err, error_count, read_count} !== {4'b0100, 1'b1, 32'd1, 32'd8}) begin
      $display("FAIL err_range_rsp: got valid=%b err=%b errs=%0d rd=%0d want 0100/1/1/8", rsp_valid, rsp_err, error_count, read_count); fails++;
    end
    tests++;
    step(); #1;
    if ({rsp_valid, rsp_we, rsp_err, rsp_rdata, error_count} !== {4'b1000, 2'b11, 32'h0, 32'd2}) begin
      $display("FAIL err_size_rsp: got valid=%b we=%b err=%b rdata=%h errs=%0d want 1000/1/1/0/2", rsp_valid, rsp_we, rsp_err, rsp_rdata, error_count); fails++;
    end
    tests++;
    step(); #1;
    if ({error_count, read_count, write_count, bytes_transferred} !== {32'd3, 32'd8, 32'd2, 32'd35}) begin
      $display("FAIL err_counts: got errs=%0d rd=%0d wr=%0d bytes=%0d want 3/8/2/35", error_count, read_count, write_count, bytes_transferred); fails++;
    end
    tests++;
  endtask

  task automatic test_reset_midflight();
    drive(0, 1'b0, SW, 32'h10, 32'h0); #1;
    if (req_ready !== 4'b0001) begin $display("FAIL mid_accept: got %b want 0001", req_ready); fails++; end
    tests++;
    step(); idle(); reset = 1'b1;
    step(); #1;
    if ({rsp_valid, init_done, read_count, bytes_transferred, error_count, write_count, conflict_cycles} !== 165'h0) begin
      $display("FAIL mid_reset_state: got valid=%b init=%b rd=%0d bytes=%0d errs=%0d wr=%0d conf=%0d want all 0",
               rsp_valid, init_done, read_count, bytes_transferred, error_count, write_count, conflict_cycles); fails++;
    end
    tests++;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ({init_done, rsp_valid, read_count} !== 37'h0) begin
        $display("FAIL mid_reinit_c%0d: got init=%b valid=%b rd=%0d want 0", i, init_done, rsp_valid, read_count); fails++;
      end
      tests++;
      step(); #1;
    end
    if (init_done !== 1'b1) begin $display("FAIL mid_init_done: got %b want 1", init_done); fails++; end
    tests++;
  endtask

  initial begin
    reset = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    idle();
    step();
    ld_en = 1'b1; ld_addr = 13'd4; ld_data = 32'hDEADBEEF;
    step();
    ld_addr = 13'd8; ld_data = 32'h0;
    step();
    ld_en = 1'b0;
    test_reset();
    test_init_gating();
    test_single_read();
    test_byte_half();
    test_round_robin();
    test_errors();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
